bin_to_bcd_display: RTL and testbench
=====================================

# bin_to_bcd_display

Sequential binary-to-BCD converter that sits directly upstream of the per-digit 7-segment hex decoders on the board display path. It accepts an unsigned binary value on a start strobe and runs a shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents a registered, stable set of BCD digits plus a leading-zero valid mask. Each 4-bit digit drives one decoder instance, so the display shows decimal instead of hex.

## Interface
- WIDTH, 16, bit width of the binary input; the constraint 10^DIGITS > 2^WIDTH − 1 must hold.
- DIGITS, 5, number of BCD digits produced.
- clk  input  1  system clock; all state changes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately while low.
- start  input  1  conversion request, sampled on a rising clk edge only in IDLE.
- binaryValue  input  WIDTH  unsigned value to convert, captured on the accepted start edge.
- busy  output  1  high in SHIFT and DONE; low in IDLE.
- done  output  1  one-cycle pulse when a new result has been loaded into bcdOut.
- bcdOut  output  4*DIGITS  registered result; digit i occupies bits [4i+3:4i], and digit 0 is the ones digit.
- digitValid  output  DIGITS  bit i high if digit i or any higher digit is nonzero; bit 0 is always 1. Intended for blanking leading zeros.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: one algorithm step per cycle.
  - DONE: result-publish cycle.
- IDLE → SHIFT on start=1.
  - The input register is loaded with binaryValue.
  - The scratch BCD register is cleared.
  - The bit counter is loaded with WIDTH.
- SHIFT, each cycle:
  - Each scratch digit ≥ 5 has 3 added; digit arithmetic is 4-bit, and no carry crosses digits.
  - The scratch BCD register, concatenated with the input register, is then shifted left by 1.
  - The input register MSB enters scratch digit 0 bit 0.
  - The counter decrements.
- SHIFT → DONE when the counter reaches 0, after exactly WIDTH shift cycles.
- DONE:
  - bcdOut ← scratch, and digitValid is recomputed from the new value.
  - done is 1 for exactly this cycle.
  - The next state is IDLE unconditionally.
- Outside the DONE cycle, bcdOut and digitValid hold their last published value. Intermediate scratch values are never visible on the outputs.
- start asserted in SHIFT or DONE is ignored; no queuing. Changes to binaryValue after capture have no effect.
- Reset low at any time:
  - state → IDLE; counter, scratch, bcdOut → 0.
  - digitValid → 1 (bit 0 only); busy = 0; done = 0.
  - Any conversion in progress is abandoned, and no done pulse is issued for it.

## Timing
- start is accepted on edge E0. busy is high from E0 through E0+WIDTH+1.
- done and the new bcdOut are visible after edge E0+WIDTH+1.
  - Latency is WIDTH+1 cycles; with the default parameters, 17 cycles.
- The earliest next accepted start is the edge after DONE (E0+WIDTH+2). Sustained throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Reset assertion is asynchronous. Release is sampled by clk; the first start can be accepted on the first edge with reset high.

## Test plan
- Reset: hold reset=0 with random inputs. Required: bcdOut=0x00000, digitValid=5'b00001, busy=0, done=0. Assert reset mid-SHIFT: same values immediately, and no done afterwards.
- Zero: start with binaryValue=0. Required: done after exactly 17 cycles, bcdOut=0x00000, digitValid=5'b00001, busy low the following cycle.
- Max: binaryValue=65535. Required: bcdOut=0x65535, digitValid=5'b11111. binaryValue=1234: bcdOut=0x01234, digitValid=5'b01111.
- Ignored start: start with 42, then pulse start with 999 during SHIFT and again during DONE. Required: exactly one done, bcdOut=0x00042, digitValid=5'b00011.
- Back-to-back: start with 100, then assert start with 9 on the first IDLE edge after done. Required: two done pulses 18 cycles apart, with bcdOut=0x00100 and then 0x00009. Outputs hold 0x00100 throughout the second conversion.
- Random sweep: 1000 random values. The scoreboard compares bcdOut against a decimal model and checks done spacing and busy framing.

Source files
------------

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) feeding
// the per-digit 7-segment decoders; publishes a stable result and leading-zero mask.
module bin_to_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binaryValue,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic [DIGITS-1:0]     digitValid
);

  // state | meaning
  // IDLE  | waiting for start, outputs hold last published result
  // SHIFT | one add-3 / shift step per cycle, WIDTH steps total
  // DONE  | publish scratch to bcdOut / digitValid, pulse done

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH-1:0]    bin_reg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [CW-1:0]       count;
  logic [DIGITS-1:0]   valid_next;

  // Per-digit add-3 correction; 4-bit arithmetic, no carry between digits.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i is shown if it or any more significant digit is nonzero.
  always_comb begin
    valid_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      valid_next[i] = |(scratch >> (4*i));
    end
    valid_next[0] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_reg    <= '0;
      scratch    <= '0;
      count      <= '0;
      bcdOut     <= '0;
      digitValid <= DIGITS'(1);
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg <= binaryValue;
            scratch <= '0;
            count   <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          {scratch, bin_reg} <= {scratch_adj, bin_reg} << 1;
          count              <= count - CW'(1);
        end
        DONE: begin
          bcdOut     <= scratch;
          digitValid <= valid_next;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display: directed cases plus a random sweep
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_display;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = WIDTH + 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  binaryValue;
  logic              busy;
  logic              done;
  logic [19:0]       bcdOut;
  logic [DIGITS-1:0] digitValid;

  int errors = 0;
  int checks = 0;
  logic [19:0] last_bcd;

  bin_to_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .binaryValue(binaryValue),
    .busy(busy), .done(done), .bcdOut(bcdOut), .digitValid(digitValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_valid(input int unsigned v);
    logic [DIGITS-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
    return r;
  endfunction

  // Called just after a negedge; returns just after the negedge following E0.
  task automatic start_conv(input logic [WIDTH-1:0] v);
    start = 1'b1;
    binaryValue = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    binaryValue = WIDTH'($urandom);
  endtask

  // n = number of edges after E0 at which done was first seen.
  task automatic wait_done(input logic [19:0] held, output int n,
                           output int busy_bad, output int hold_bad);
    n = 0;
    busy_bad = 0;
    hold_bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_bad++;
      if (bcdOut !== held) hold_bad++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start = 1'($urandom);
      binaryValue = WIDTH'($urandom);
      @(negedge clk);
      checks++; if (bcdOut !== 20'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=%h", bcdOut, 20'h0); end
      checks++; if (digitValid !== 5'b00001) begin errors++; $display("FAIL reset_valid got=%b exp=%b", digitValid, 5'b00001); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    end
    start = 1'b0;
    reset = 1'b1;
    last_bcd = 20'h0;
    @(negedge clk);
  endtask

  task automatic test_known_values();
    logic [WIDTH-1:0] vals [3];
    int n, bb, hb;
    vals[0] = 16'd0;
    vals[1] = 16'd65535;
    vals[2] = 16'd1234;
    for (int t = 0; t < 3; t++) begin
      start_conv(vals[t]);
      wait_done(last_bcd, n, bb, hb);
      checks++; if (n !== LAT) begin errors++; $display("FAIL known_latency v=%0d got=%0d exp=%0d", vals[t], n, LAT); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL known_busy_frame v=%0d got=%0d exp=0", vals[t], bb); end
      checks++; if (hb !== 0) begin errors++; $display("FAIL known_hold v=%0d got=%0d exp=0", vals[t], hb); end
      checks++; if (bcdOut !== model_bcd(32'(vals[t]))) begin errors++; $display("FAIL known_bcd v=%0d got=%h exp=%h", vals[t], bcdOut, model_bcd(32'(vals[t]))); end
      checks++; if (digitValid !== model_valid(32'(vals[t]))) begin errors++; $display("FAIL known_valid v=%0d got=%b exp=%b", vals[t], digitValid, model_valid(32'(vals[t]))); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL known_busy_after v=%0d got=%b exp=0", vals[t], busy); end
      last_bcd = model_bcd(32'(vals[t]));
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL known_done_pulse v=%0d got=%b exp=0", vals[t], done); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int dones;
    start_conv(16'd54321);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bcdOut !== 20'h0) begin errors++; $display("FAIL midrst_bcd got=%h exp=%h", bcdOut, 20'h0); end
    checks++; if (digitValid !== 5'b00001) begin errors++; $display("FAIL midrst_valid got=%b exp=%b", digitValid, 5'b00001); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    @(negedge clk);
    reset = 1'b1;
    last_bcd = 20'h0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ignored_start();
    int dones, done_at;
    dones = 0;
    done_at = -1;
    start_conv(16'd42);
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin dones++; done_at = k; end
      start = (k == 5 || k == 16);
      binaryValue = start ? 16'd999 : WIDTH'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    checks++; if (done_at !== LAT) begin errors++; $display("FAIL ign_done_at got=%0d exp=%0d", done_at, LAT); end
    checks++; if (bcdOut !== 20'h00042) begin errors++; $display("FAIL ign_bcd got=%h exp=%h", bcdOut, 20'h00042); end
    checks++; if (digitValid !== 5'b00011) begin errors++; $display("FAIL ign_valid got=%b exp=%b", digitValid, 5'b00011); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b exp=0", busy); end
    last_bcd = 20'h00042;
  endtask

  task automatic test_back_to_back();
    int n1, n2, bb, hb;
    start_conv(16'd100);
    wait_done(last_bcd, n1, bb, hb);
    checks++; if (n1 !== LAT) begin errors++; $display("FAIL b2b_latency1 got=%0d exp=%0d", n1, LAT); end
    checks++; if (bcdOut !== 20'h00100) begin errors++; $display("FAIL b2b_bcd1 got=%h exp=%h", bcdOut, 20'h00100); end
    start_conv(16'd9);
    wait_done(20'h00100, n2, bb, hb);
    checks++; if (n2 + 1 !== LAT + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", n2 + 1, LAT + 1); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL b2b_hold got=%0d exp=0", hb); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL b2b_busy_frame got=%0d exp=0", bb); end
    checks++; if (bcdOut !== 20'h00009) begin errors++; $display("FAIL b2b_bcd2 got=%h exp=%h", bcdOut, 20'h00009); end
    checks++; if (digitValid !== 5'b00001) begin errors++; $display("FAIL b2b_valid2 got=%b exp=%b", digitValid, 5'b00001); end
    last_bcd = 20'h00009;
  endtask

  task automatic test_random_sweep();
    int n, bb, hb, gap;
    logic [WIDTH-1:0] v;
    for (int t = 0; t < 1000; t++) begin
      v = WIDTH'($urandom);
      start_conv(v);
      wait_done(last_bcd, n, bb, hb);
      checks++; if (n !== LAT) begin errors++; $display("FAIL rnd_latency v=%0d got=%0d exp=%0d", v, n, LAT); end
      checks++; if (bb !== 0 || hb !== 0) begin errors++; $display("FAIL rnd_frame v=%0d got=busy_bad %0d hold_bad %0d exp=0", v, bb, hb); end
      checks++; if (bcdOut !== model_bcd(32'(v))) begin errors++; $display("FAIL rnd_bcd v=%0d got=%h exp=%h", v, bcdOut, model_bcd(32'(v))); end
      checks++; if (digitValid !== model_valid(32'(v))) begin errors++; $display("FAIL rnd_valid v=%0d got=%b exp=%b", v, digitValid, model_valid(32'(v))); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy_after v=%0d got=%b exp=0", v, busy); end
      last_bcd = model_bcd(32'(v));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_idle v=%0d got=%b exp=0", v, done); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    binaryValue = '0;
    last_bcd = 20'h0;
    @(negedge clk);
    test_reset();
    test_known_values();
    test_reset_mid_shift();
    test_ignored_start();
    test_back_to_back();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
